// File: rtl/feeder_pkg.sv
// Shared constants and types for the systolic array operand feeder.
package feeder_pkg;

  localparam logic [2:0] PE_CLEAR = 3'd0;
  localparam logic [2:0] PE_ACC   = 3'd1;

  localparam int DEF_N    = 4;
  localparam int DEF_DW   = 8;
  localparam int DEF_KMAX = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/feeder_buf.sv
// k-slice buffer: one write port, one registered read port.
module feeder_buf #(
  parameter int DEPTH = 16,
  parameter int W     = 64,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Write-through bypass lets a K=1 tile read its only slice on the next cycle.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
  end

endmodule

// File: rtl/systolic_feeder.sv
// Buffers one tile of k-slices, then streams them into the PE array edges.
// Optional FEEDER_SKEW_EN delays lane i by i cycles for a wavefront array.
module systolic_feeder
  import feeder_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int DW   = DEF_DW,
  parameter int KMAX = DEF_KMAX
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [N*DW-1:0] s_a,
  input  logic [N*DW-1:0] s_b,
  input  logic            s_last,
  output logic [N*DW-1:0] a_out,
  output logic [N*DW-1:0] b_out,
  output logic [2:0]      pe_state,
  output logic            busy,
  output logic            done
);

  localparam int SW = N * DW;
  localparam int AW = (KMAX > 1) ? $clog2(KMAX) : 1;
  localparam int CW = $clog2(KMAX + 1);
  localparam int TW = $clog2(KMAX + N);

  feeder_state_t state, state_nxt;
  logic [CW-1:0] wr_cnt, k_reg;
  logic [TW-1:0] t, run_len;
  logic          accept, final_beat, run_end;
  logic [AW-1:0] raddr;
  logic [2*SW-1:0] rdata;
  logic [SW-1:0] lane_a, lane_b;

  assign accept     = s_valid && s_ready;
  assign final_beat = accept && (s_last || (wr_cnt == CW'(KMAX - 1)));
  assign run_end    = (t == run_len - TW'(1));

  // Outside RUN keep address 0 primed so slice 0 is ready on the first RUN cycle.
  always_comb begin
    raddr = '0;
    if ((state == ST_RUN) && ((t + TW'(1)) < TW'(k_reg)))
      raddr = AW'(t + TW'(1));
  end

  feeder_buf #(.DEPTH(KMAX), .W(2*SW), .AW(AW)) u_buf (
    .clk   (clk),
    .we    (accept),
    .waddr (AW'(wr_cnt)),
    .wdata ({s_b, s_a}),
    .raddr (raddr),
    .rdata (rdata)
  );

`ifdef FEEDER_SKEW_EN
  logic [2*SW-1:0] cur;
  assign cur     = (t < TW'(k_reg)) ? rdata : '0;
  assign run_len = TW'(k_reg) + TW'(N - 1);

  for (genvar i = 0; i < N; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign lane_a[DW-1:0] = cur[DW-1:0];
      assign lane_b[DW-1:0] = cur[SW +: DW];
    end else begin : g_delay
      logic [DW-1:0] sr_a [i];
      logic [DW-1:0] sr_b [i];
      always_ff @(posedge clk or posedge rst) begin
        if (rst || (state != ST_RUN)) begin
          for (int j = 0; j < i; j++) begin
            sr_a[j] <= '0;
            sr_b[j] <= '0;
          end
        end else begin
          sr_a[0] <= cur[i*DW +: DW];
          sr_b[0] <= cur[SW + i*DW +: DW];
          for (int j = 1; j < i; j++) begin
            sr_a[j] <= sr_a[j-1];
            sr_b[j] <= sr_b[j-1];
          end
        end
      end
      assign lane_a[i*DW +: DW] = sr_a[i-1];
      assign lane_b[i*DW +: DW] = sr_b[i-1];
    end
  end
`else
  assign lane_a  = rdata[SW-1:0];
  assign lane_b  = rdata[2*SW-1:SW];
  assign run_len = TW'(k_reg);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = final_beat ? ST_RUN : ST_LOAD;
      ST_LOAD: if (final_beat) state_nxt = ST_RUN;
      ST_RUN:  if (run_end) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt <= '0;
      k_reg  <= '0;
      t      <= '0;
    end else begin
      if (final_beat) begin
        wr_cnt <= '0;
        k_reg  <= wr_cnt + CW'(1);
      end else if (accept) begin
        wr_cnt <= wr_cnt + CW'(1);
      end
      if ((state == ST_RUN) && !run_end) t <= t + TW'(1);
      else                               t <= '0;
    end
  end

  always_comb begin
    s_ready  = (state == ST_IDLE) || (state == ST_LOAD);
    busy     = (state != ST_IDLE);
    done     = (state == ST_DONE);
    pe_state = PE_CLEAR;
    a_out    = '0;
    b_out    = '0;
    if (state == ST_RUN) begin
      pe_state = PE_ACC;
      a_out    = lane_a;
      b_out    = lane_b;
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder with a queue-based scoreboard of edge operands.
module tb_systolic_feeder;
  import feeder_pkg::*;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int KMAX = 16;
  localparam int SW   = N * DW;
  localparam int W    = 2 * SW;
`ifdef FEEDER_SKEW_EN
  localparam bit SKEW = 1'b1;
`else
  localparam bit SKEW = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, s_valid, s_ready, s_last, busy, done;
  logic [SW-1:0] s_a, s_b, a_out, b_out;
  logic [2:0]    pe_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0]  exp_q[$];
  logic [SW-1:0] tile_a[$];
  logic [SW-1:0] tile_b[$];
  logic [W-1:0]  pe_acc;

  systolic_feeder #(.N(N), .DW(DW), .KMAX(KMAX)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_a(s_a), .s_b(s_b), .s_last(s_last), .a_out(a_out), .b_out(b_out),
    .pe_state(pe_state), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference PE(0,0): accumulates lane 0 on ACC, clears otherwise.
  always @(posedge clk) begin
    if (pe_state == PE_ACC) pe_acc <= pe_acc + W'(a_out[DW-1:0]) * W'(b_out[DW-1:0]);
    else                    pe_acc <= '0;
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic gen_tile(input int k);
    tile_a.delete();
    tile_b.delete();
    for (int j = 0; j < k; j++) begin
      tile_a.push_back(SW'($urandom()));
      tile_b.push_back(SW'($urandom_range(32'hffff_ffff, 0)));
    end
  endtask

  task automatic push_expected(input int k);
    int len;
    logic [SW-1:0] ea, eb, sla, slb;
    len = SKEW ? k + N - 1 : k;
    for (int t = 0; t < len; t++) begin
      ea = '0;
      eb = '0;
      for (int i = 0; i < N; i++) begin
        int idx;
        idx = SKEW ? t - i : t;
        if (idx >= 0 && idx < k) begin
          sla = tile_a[idx];
          slb = tile_b[idx];
          ea[i*DW +: DW] = sla[i*DW +: DW];
          eb[i*DW +: DW] = slb[i*DW +: DW];
        end
      end
      exp_q.push_back({eb, ea});
    end
  endtask

  function automatic logic [W-1:0] tile_sum(input int k);
    logic [W-1:0]  s;
    logic [SW-1:0] a, b;
    s = '0;
    for (int j = 0; j < k; j++) begin
      a = tile_a[j];
      b = tile_b[j];
      s = s + W'(a[DW-1:0]) * W'(b[DW-1:0]);
    end
    return s;
  endfunction

  task automatic present(input int j, input bit last);
    s_valid = 1'b1;
    s_a     = tile_a[j];
    s_b     = tile_b[j];
    s_last  = last;
  endtask

  // Offers beats first..k-1; returns how many cycles beat 'first' waited for s_ready.
  task automatic drive_beats(input int first, input int k, input bit use_last, output int wait0);
    int  w;
    bit  acc, rdy;
    wait0 = 0;
    for (int j = first; j < k; j++) begin
      present(j, use_last && (j == k - 1));
      w   = 0;
      acc = 1'b0;
      while (!acc && w < 40) begin
        rdy = s_ready;
        step();
        if (rdy) acc = 1'b1;
        else     w++;
      end
      if (!acc) begin
        checks++;
        errors++;
        $error("FAIL accept_timeout: beat %0d not accepted within %0d cycles", j, w);
      end
      if (j == first) wait0 = w;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Called in the first RUN cycle; walks RUN, DONE and the following IDLE cycle.
  task automatic run_check(input int k, input string tag);
    int len;
    logic [W-1:0] e;
    len = SKEW ? k + N - 1 : k;
    for (int t = 0; t < len; t++) begin
      check({tag, "_pe_acc"}, W'(pe_state), W'(PE_ACC));
      check({tag, "_done_low"}, W'(done), W'(1'b0));
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL %s_queue: observed empty expected entry at t=%0d", tag, t);
      end else begin
        e = exp_q.pop_front();
        check({tag, "_operands"}, {b_out, a_out}, e);
      end
      step();
    end
    check({tag, "_done"}, W'(done), W'(1'b1));
    check({tag, "_done_pe_clear"}, W'(pe_state), W'(PE_CLEAR));
    check({tag, "_done_zero_out"}, {b_out, a_out}, '0);
    check({tag, "_done_ready"}, W'(s_ready), W'(1'b0));
    check({tag, "_pe00_sum"}, pe_acc, tile_sum(k));
    step();
    check({tag, "_idle_done"}, W'(done), W'(1'b0));
    check({tag, "_idle_ready"}, W'(s_ready), W'(1'b1));
  endtask

  initial begin
    int w0;
    rst     = 1'b1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_a     = '0;
    s_b     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", W'(s_ready), W'(1'b1));
    check("rst_busy", W'(busy), W'(1'b0));
    check("rst_done", W'(done), W'(1'b0));
    check("rst_pe", W'(pe_state), W'(PE_CLEAR));
    check("rst_out", {b_out, a_out}, '0);
    rst = 1'b0;
    repeat (3) step();
    check("idle_hold", W'(busy), W'(1'b0));

    // Three slices, s_last on the third.
    gen_tile(3);
    push_expected(3);
    drive_beats(0, 3, 1'b1, w0);
    check("k3_first_wait", W'(w0), W'(0));
    run_check(3, "k3");

    // Two slices; exercises the lane-delay shape when skew is built in.
    gen_tile(2);
    push_expected(2);
    drive_beats(0, 2, 1'b1, w0);
    run_check(2, "k2");

    // KMAX beats without s_last force the run.
    gen_tile(KMAX);
    push_expected(KMAX);
    drive_beats(0, KMAX, 1'b0, w0);
    check("forced_ready_drop", W'(s_ready), W'(1'b0));
    check("forced_busy", W'(busy), W'(1'b1));
    run_check(KMAX, "forced");

    // Single-slice tile straight from IDLE.
    gen_tile(1);
    push_expected(1);
    drive_beats(0, 1, 1'b1, w0);
    run_check(1, "k1");

    // Reset during t=1 of a K=4 run aborts the tile.
    gen_tile(4);
    push_expected(4);
    drive_beats(0, 4, 1'b1, w0);
    check("abort_t0", {b_out, a_out}, exp_q.pop_front());
    step();
    check("abort_t1", {b_out, a_out}, exp_q.pop_front());
    rst = 1'b1;
    #1;
    check("abort_out", {b_out, a_out}, '0);
    check("abort_pe", W'(pe_state), W'(PE_CLEAR));
    check("abort_busy", W'(busy), W'(1'b0));
    check("abort_ready", W'(s_ready), W'(1'b1));
    check("abort_done", W'(done), W'(1'b0));
    #2;
    rst = 1'b0;
    exp_q.delete();
    for (int c = 0; c < 8; c++) begin
      step();
      check("abort_no_done", W'(done), W'(1'b0));
    end

    gen_tile(3);
    push_expected(3);
    drive_beats(0, 3, 1'b1, w0);
    run_check(3, "after_abort");

    // s_valid held across DONE: next tile's first beat waits, then goes in right after DONE.
    gen_tile(2);
    push_expected(2);
    drive_beats(0, 2, 1'b1, w0);
    begin
      logic [SW-1:0] nxt_a[$];
      logic [SW-1:0] nxt_b[$];
      logic [SW-1:0] cur_a[$];
      logic [SW-1:0] cur_b[$];
      cur_a = tile_a;
      cur_b = tile_b;
      gen_tile(3);
      nxt_a = tile_a;
      nxt_b = tile_b;
      present(0, 1'b0);
      tile_a = cur_a;
      tile_b = cur_b;
      run_check(2, "b2b_first");
      tile_a = nxt_a;
      tile_b = nxt_b;
    end
    push_expected(3);
    drive_beats(0, 3, 1'b1, w0);
    check("b2b_accept_wait", W'(w0), W'(0));
    run_check(3, "b2b_second");

    check("queue_drained", W'(exp_q.size()), W'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 The module SHALL have parameter N, default 4, meaning PE lanes per operand edge.
REQ-002 The module SHALL have parameter DW, default 8, meaning operand width, matching the PE a_in/b_in width.
REQ-003 The module SHALL have parameter KMAX, default 16, meaning maximum k-slices buffered per tile.
REQ-004 The module SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 The module SHALL have port rst, input, 1, the reset: asynchronous, active-high.
REQ-006 The module SHALL have port s_valid, input, 1, meaning the host offers a k-slice.
REQ-007 The module SHALL have port s_ready, output, 1, meaning the feeder accepts a k-slice.
REQ-008 The module SHALL have port s_a, input, N*DW, meaning the A column slice; lane i is bits [i*DW +: DW].
REQ-009 The module SHALL have port s_b, input, N*DW, meaning the B row slice, with the same lane packing as s_a.
REQ-010 The module SHALL have port s_last, input, 1, meaning the final slice of the tile.
REQ-011 The module SHALL have port a_out, output, N*DW, meaning the A operands to the array row edge.
REQ-012 The module SHALL have port b_out, output, N*DW, meaning the B operands to the array column edge.
REQ-013 The module SHALL have port pe_state, output, 3, meaning the PE command: 3'd1 = accumulate, 3'd0 = clear.
REQ-014 The module SHALL have port busy, output, 1, meaning the module is in LOAD, RUN or DONE.
REQ-015 The module SHALL have port done, output, 1, a one-cycle pulse; PE c_out is final in this cycle.

Function
REQ-016 The module SHALL implement FSM states IDLE, LOAD, RUN and DONE.
REQ-017 The module SHALL hold s_ready=1 in IDLE and LOAD and s_ready=0 in RUN and DONE.
REQ-018 The module SHALL treat a slice as accepted on any cycle where s_valid and s_ready are both 1, writing it to buffer address wr_cnt and incrementing wr_cnt.
REQ-019 The module SHALL go from IDLE to LOAD on an accepted beat with s_last=0.
REQ-020 The module SHALL go from IDLE to RUN on an accepted beat with s_last=1, which makes a tile with K=1.
REQ-021 The module SHALL go from LOAD to RUN on an accepted beat with s_last=1, or on the KMAX-th accepted beat (forced last); K is latched as the accepted count.
REQ-022 The module SHALL keep busy=0 in IDLE; s_valid=0 in IDLE SHALL NOT change state.
REQ-023 In RUN, the module SHALL drive pe_state=3'd1 on every cycle, with run counter t running from 0 to L-1, where L is the run length.
REQ-024 In RUN, the module SHALL drive the lane-i operands from buffer slice t; without skew, L=K.
REQ-025 The module SHALL transition RUN->DONE after t=L-1; DONE SHALL last exactly one cycle with done=1 and pe_state=3'd0, then go to IDLE.
REQ-026 Outside RUN, the module SHALL drive a_out=0, b_out=0 and pe_state=3'd0.
REQ-027 The buffer read SHALL be registered and pre-fetched so that slice 0 appears on the first RUN cycle, giving no bubble between LOAD and RUN.
REQ-028 Back-to-back operation SHALL be supported: a new tile can be accepted in the cycle after DONE.

Reset
REQ-029 Asserting rst SHALL immediately force IDLE, wr_cnt=0, K=0, t=0, s_ready=1, busy=0, done=0, pe_state=3'd0 and a_out=b_out=0.
REQ-030 Buffer contents SHALL be don't-care after reset.
REQ-031 A reset asserted mid-RUN SHALL abort the tile with no done pulse, and PEs receive the clear command.

Configuration
REQ-032 When FEEDER_SKEW_EN is defined, the module SHALL delay lane i by i cycles, so lane i in run cycle t carries slice t-i, or 0 when t-i<0 or t-i≥K.
REQ-033 When FEEDER_SKEW_EN is defined, the run length SHALL be L=K+N-1.
REQ-034 When FEEDER_SKEW_EN is undefined, all lanes SHALL be aligned with L=K and no skew registers SHALL be present.

Structure
REQ-035 Package feeder_pkg SHALL hold PE_CLEAR=3'd0, PE_ACC=3'd1, the FSM state enum, and default N, DW and KMAX.
REQ-036 Sub-module feeder_buf SHALL implement a KMAX x 2*N*DW simple dual-port register file with one write port and a registered read port.
REQ-037 The FSM, counters and skew logic SHALL reside in systolic_feeder.

Verification
REQ-038 Bench scenario: N=4, skew off, 3 slices with s_last on the 3rd -> 3 RUN cycles with pe_state=1, slices in order, done on the 4th cycle after the last accept, and PE(0,0) c_out = sum a0k*b0k.
REQ-039 Bench scenario: skew on, K=2 -> L=5; lane 3 is zero for t=0..2, carries slices 0 and 1 at t=3..4, and done in the next cycle.
REQ-040 Bench scenario: 16 beats with s_last=0 -> forced RUN after beat 16, and s_ready drops the following cycle.
REQ-041 Bench scenario: K=1 via s_last on the first beat from IDLE -> one RUN cycle, then done.
REQ-042 Bench scenario: rst pulsed at t=1 of a K=4 run -> outputs are 0 within the same cycle, no done, and the next tile runs normally.
REQ-043 Bench scenario: s_valid held high across DONE -> the first beat of the next tile is accepted in the cycle after DONE with no data loss.
